// File: rtl/imsic_pkg.sv
// Shared constants and helpers for the IMSIC top-external-interrupt selector.
// xtopei field placement and the scan counter width live here.
package imsic_pkg;

    localparam int unsigned ID_LSB     = 16;
    localparam int unsigned ID_MSB     = 26;
    localparam int unsigned PRIO_LSB   = 0;
    localparam int unsigned PRIO_MSB   = 10;
    localparam int unsigned XTOPEI_W   = 32;
    localparam int unsigned CLAIM_ID_W = ID_MSB - ID_LSB + 1;

    function automatic int unsigned cnt_width(input int unsigned nr_reg);
        return (nr_reg > 1) ? $clog2(nr_reg) : 1;
    endfunction

    // Identity and priority fields carry the same value; all other bits read as zero.
    function automatic logic [XTOPEI_W-1:0] xtopei_pack(input logic vld,
                                                         input logic [CLAIM_ID_W-1:0] id);
        logic [XTOPEI_W-1:0] word;
        word = '0;
        if (vld) begin
            word[ID_MSB:ID_LSB]     = id;
            word[PRIO_MSB:PRIO_LSB] = id;
        end
        return word;
    endfunction

endpackage

// File: rtl/imsic_topei_scan_if.sv
// Bundle between the CSR block, the claim requester and the top-interrupt selector.
// The master drives pending state and claims; the slave (selector) returns results.
interface imsic_topei_scan_if #(
    parameter int unsigned NR_INTP_FILES   = 7,
    parameter int unsigned XLEN            = 64,
    parameter int unsigned NR_SRC_WIDTH    = 8,
    parameter int unsigned NR_REG          = 4,
    parameter int unsigned INTP_FILE_WIDTH = 3
);
    localparam int unsigned BITS_W = NR_INTP_FILES * NR_REG * XLEN;

    logic [BITS_W-1:0]                         eip;
    logic [BITS_W-1:0]                         eie;
    logic [NR_INTP_FILES*NR_SRC_WIDTH-1:0]     eithreshold;
    logic [NR_INTP_FILES-1:0]                  eidelivery;
    logic [NR_INTP_FILES-1:0]                  cfg_chg;
    logic                                      claim_vld;
    logic [INTP_FILE_WIDTH-1:0]                claim_file;
    logic                                      claim_ack;
    logic [NR_SRC_WIDTH-1:0]                   claim_id;
    logic                                      eip_clr_vld;
    logic [INTP_FILE_WIDTH-1:0]                eip_clr_file;
    logic [NR_SRC_WIDTH-1:0]                   eip_clr_id;
    logic [NR_INTP_FILES*imsic_pkg::XTOPEI_W-1:0] xtopei;
    logic [NR_INTP_FILES-1:0]                  o_irq;

    modport master (
        output eip, eie, eithreshold, eidelivery, cfg_chg, claim_vld, claim_file,
        input  claim_ack, claim_id, eip_clr_vld, eip_clr_file, eip_clr_id, xtopei, o_irq
    );

    modport slave (
        input  eip, eie, eithreshold, eidelivery, cfg_chg, claim_vld, claim_file,
        output claim_ack, claim_id, eip_clr_vld, eip_clr_file, eip_clr_id, xtopei, o_irq
    );

endinterface

// File: rtl/imsic_topei_file_scan.sv
// Sequential top-interrupt search for one interrupt file: one eip/eie word per cycle,
// first-hit accumulation, commit at the end of each sweep, claim masking.
module imsic_topei_file_scan
    import imsic_pkg::*;
#(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned NR_SRC_WIDTH = 8,
    parameter int unsigned NR_REG       = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NR_REG*XLEN-1:0]    i_eip,
    input  logic [NR_REG*XLEN-1:0]    i_eie,
    input  logic [NR_SRC_WIDTH-1:0]   i_threshold,
    input  logic                      i_cfg_chg,
    input  logic                      i_claim,
    output logic                      o_vld,
    output logic [NR_SRC_WIDTH-1:0]   o_id,
    output logic                      o_vld_d
);
    localparam int unsigned CNT_W = cnt_width(NR_REG);

    logic [CNT_W-1:0]        r_cnt, w_cnt_d;
    logic                    r_best_vld, w_best_vld_d;
    logic [NR_SRC_WIDTH-1:0] r_best_id, w_best_id_d;
    logic [NR_SRC_WIDTH-1:0] r_mask, w_mask_d;
    logic                    r_com_vld, w_com_vld_d;
    logic [NR_SRC_WIDTH-1:0] r_com_id, w_com_id_d;

    logic [XLEN-1:0]         w_word;
    logic [NR_SRC_WIDTH-1:0] w_base;
    logic [NR_SRC_WIDTH-1:0] w_cand;
    logic                    w_hit;
    logic [NR_SRC_WIDTH-1:0] w_hit_id;
    logic                    w_last;

    // Lowest qualifying identity in the current word; identity 0 is never valid.
    always_comb begin
        w_word   = i_eip[XLEN*32'(r_cnt) +: XLEN] & i_eie[XLEN*32'(r_cnt) +: XLEN];
        w_base   = NR_SRC_WIDTH'(XLEN * 32'(r_cnt));
        w_cand   = '0;
        w_hit    = 1'b0;
        w_hit_id = '0;
        for (int unsigned j = 0; j < XLEN; j++) begin
            w_cand = w_base + NR_SRC_WIDTH'(j);
            if (!w_hit && w_word[j] && (w_cand != '0) && (w_cand != r_mask) &&
                ((i_threshold == '0) || (w_cand < i_threshold))) begin
                w_hit    = 1'b1;
                w_hit_id = w_cand;
            end
        end
    end

    always_comb begin
        w_last       = (r_cnt == CNT_W'(NR_REG - 1));
        w_cnt_d      = w_last ? '0 : r_cnt + CNT_W'(1);
        w_best_vld_d = r_best_vld | w_hit;
        w_best_id_d  = r_best_vld ? r_best_id : w_hit_id;
        w_mask_d     = r_mask;
        w_com_vld_d  = r_com_vld;
        w_com_id_d   = r_com_id;
        if (i_claim) begin
            // Mask the claimed id until the next commit so a late eip clear cannot re-report it.
            w_cnt_d      = '0;
            w_best_vld_d = 1'b0;
            w_best_id_d  = '0;
            w_mask_d     = r_com_vld ? r_com_id : '0;
            w_com_vld_d  = 1'b0;
            w_com_id_d   = '0;
        end else if (i_cfg_chg) begin
            w_cnt_d      = '0;
            w_best_vld_d = 1'b0;
            w_best_id_d  = '0;
        end else if (w_last) begin
            w_com_vld_d  = w_best_vld_d;
            w_com_id_d   = w_best_id_d;
            w_mask_d     = '0;
            w_best_vld_d = 1'b0;
            w_best_id_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt      <= '0;
            r_best_vld <= 1'b0;
            r_best_id  <= '0;
            r_mask     <= '0;
            r_com_vld  <= 1'b0;
            r_com_id   <= '0;
        end else begin
            r_cnt      <= w_cnt_d;
            r_best_vld <= w_best_vld_d;
            r_best_id  <= w_best_id_d;
            r_mask     <= w_mask_d;
            r_com_vld  <= w_com_vld_d;
            r_com_id   <= w_com_id_d;
        end
    end

    assign o_vld   = r_com_vld;
    assign o_id    = r_com_id;
    assign o_vld_d = w_com_vld_d;

endmodule

// File: rtl/imsic_topei_scan.sv
// Top-external-interrupt selector: one scan engine per interrupt file plus the claim
// handshake (read-and-clear) and flattening of xtopei / o_irq.
module imsic_topei_scan
    import imsic_pkg::*;
#(
    parameter int unsigned NR_INTP_FILES   = 7,
    parameter int unsigned XLEN            = 64,
    parameter int unsigned NR_SRC_WIDTH    = 8,
    parameter int unsigned NR_REG          = 4,
    parameter int unsigned INTP_FILE_WIDTH = 3
) (
    input logic              clk,
    input logic              rstn,
    imsic_topei_scan_if.slave bus
);
    logic [NR_INTP_FILES-1:0]   w_claim_sel;
    logic [NR_INTP_FILES-1:0]   w_com_vld;
    logic [NR_INTP_FILES-1:0]   w_com_vld_d;
    logic [NR_SRC_WIDTH-1:0]    w_com_id [NR_INTP_FILES];
    logic [NR_SRC_WIDTH-1:0]    w_claim_id;

    logic                       r_claim_ack;
    logic [NR_SRC_WIDTH-1:0]    r_claim_id;
    logic                       r_clr_vld;
    logic [INTP_FILE_WIDTH-1:0] r_clr_file;
    logic [NR_SRC_WIDTH-1:0]    r_clr_id;
    logic [NR_INTP_FILES-1:0]   r_irq;

    for (genvar f = 0; f < NR_INTP_FILES; f++) begin : g_file
        // Out-of-range claim_file selects no engine, so it returns id 0 and clears nothing.
        assign w_claim_sel[f] = bus.claim_vld && (bus.claim_file == INTP_FILE_WIDTH'(f));

        imsic_topei_file_scan #(
            .XLEN         (XLEN),
            .NR_SRC_WIDTH (NR_SRC_WIDTH),
            .NR_REG       (NR_REG)
        ) u_scan (
            .clk         (clk),
            .rstn        (rstn),
            .i_eip       (bus.eip[f*NR_REG*XLEN +: NR_REG*XLEN]),
            .i_eie       (bus.eie[f*NR_REG*XLEN +: NR_REG*XLEN]),
            .i_threshold (bus.eithreshold[f*NR_SRC_WIDTH +: NR_SRC_WIDTH]),
            .i_cfg_chg   (bus.cfg_chg[f]),
            .i_claim     (w_claim_sel[f]),
            .o_vld       (w_com_vld[f]),
            .o_id        (w_com_id[f]),
            .o_vld_d     (w_com_vld_d[f])
        );

        assign bus.xtopei[f*XTOPEI_W +: XTOPEI_W] =
            xtopei_pack(w_com_vld[f], CLAIM_ID_W'(w_com_id[f]));
    end

    always_comb begin
        w_claim_id = '0;
        for (int unsigned f = 0; f < NR_INTP_FILES; f++) begin
            if (w_claim_sel[f] && w_com_vld[f]) begin
                w_claim_id = w_com_id[f];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_claim_ack <= 1'b0;
            r_claim_id  <= '0;
            r_clr_vld   <= 1'b0;
            r_clr_file  <= '0;
            r_clr_id    <= '0;
            r_irq       <= '0;
        end else begin
            r_claim_ack <= bus.claim_vld;
            r_claim_id  <= w_claim_id;
            r_clr_vld   <= bus.claim_vld && (w_claim_id != '0);
            r_clr_file  <= (bus.claim_vld && (w_claim_id != '0)) ? bus.claim_file : '0;
            r_clr_id    <= w_claim_id;
            r_irq       <= w_com_vld_d & bus.eidelivery;
        end
    end

    assign bus.claim_ack    = r_claim_ack;
    assign bus.claim_id     = r_claim_id;
    assign bus.eip_clr_vld  = r_clr_vld;
    assign bus.eip_clr_file = r_clr_file;
    assign bus.eip_clr_id   = r_clr_id;
    assign bus.o_irq        = r_irq;

endmodule

// File: tb/tb_imsic_topei_scan.sv
// Directed bench for imsic_topei_scan: scan latency, threshold, id 0, claim/mask,
// cfg_chg hold, eidelivery and reset during a claim.
module tb_imsic_topei_scan;
    localparam int unsigned NF = 7;
    localparam int unsigned XL = 64;
    localparam int unsigned SW = 8;
    localparam int unsigned NR = 4;
    localparam int unsigned FW = 3;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    imsic_topei_scan_if #(
        .NR_INTP_FILES(NF), .XLEN(XL), .NR_SRC_WIDTH(SW), .NR_REG(NR), .INTP_FILE_WIDTH(FW)
    ) bus ();

    imsic_topei_scan #(
        .NR_INTP_FILES(NF), .XLEN(XL), .NR_SRC_WIDTH(SW), .NR_REG(NR), .INTP_FILE_WIDTH(FW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    function automatic logic [31:0] topei(input int id);
        return 32'((id << 16) | id);
    endfunction

    function automatic logic [31:0] xt(input int f);
        return bus.xtopei[f*32 +: 32];
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_src(input int f, input int id, input logic v);
        bus.eip[f*NR*XL + id] = v;
        bus.eie[f*NR*XL + id] = v;
    endtask

    task automatic set_thr(input int f, input int thr);
        bus.eithreshold[f*SW +: SW] = SW'(thr);
    endtask

    // Pulse cfg_chg so the engine restarts its sweep from word 0.
    task automatic apply_change(input int f);
        bus.cfg_chg[f] = 1'b1;
        @(negedge clk);
        bus.cfg_chg[f] = 1'b0;
    endtask

    task automatic test_reset();
        rstn            = 1'b1;
        bus.eip         = '0;
        bus.eie         = '0;
        bus.eithreshold = '0;
        bus.eidelivery  = '0;
        bus.cfg_chg     = '0;
        bus.claim_vld   = 1'b0;
        bus.claim_file  = '0;
        #2 rstn = 1'b0;
        cycles(2);
        checks++;
        if ({bus.claim_ack, bus.claim_id, bus.eip_clr_vld, bus.eip_clr_file, bus.eip_clr_id,
             bus.o_irq, bus.xtopei} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ack=%b id=%0d clr=%b irq=%b xtopei=%h want all 0",
                     bus.claim_ack, bus.claim_id, bus.eip_clr_vld, bus.o_irq, bus.xtopei);
        end
        rstn = 1'b1;
        cycles(2);
    endtask

    task automatic test_scan();
        logic [NF*32-1:0] exp_xt;
        exp_xt = '0;
        exp_xt[32 +: 32] = topei(70);
        set_src(1, 70, 1'b1);
        set_src(1, 200, 1'b1);
        bus.eidelivery = '1;
        apply_change(1);
        cycles(3);
        checks++;
        if (xt(1) !== 32'h0) begin
            errors++;
            $display("FAIL scan_early: xtopei[1] got %h want 00000000", xt(1));
        end
        cycles(1);
        checks++;
        if (bus.xtopei !== exp_xt) begin
            errors++;
            $display("FAIL scan_id70: xtopei got %h want %h", bus.xtopei, exp_xt);
        end
        checks++;
        if (bus.o_irq !== 7'b0000010) begin
            errors++;
            $display("FAIL scan_irq: o_irq got %b want 0000010", bus.o_irq);
        end
    endtask

    task automatic test_threshold();
        set_thr(1, 70);
        apply_change(1);
        cycles(3);
        checks++;
        if (xt(1) !== topei(70)) begin
            errors++;
            $display("FAIL thr_hold: xtopei[1] got %h want %h", xt(1), topei(70));
        end
        cycles(1);
        checks++;
        if ({bus.o_irq[1], xt(1)} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL thr70_masked: irq=%b xtopei[1]=%h want irq=0 xtopei=0",
                     bus.o_irq[1], xt(1));
        end
        set_thr(1, 201);
        apply_change(1);
        cycles(4);
        checks++;
        if ({bus.o_irq[1], xt(1)} !== {1'b1, topei(70)}) begin
            errors++;
            $display("FAIL thr201: irq=%b xtopei[1]=%h want irq=1 xtopei=%h",
                     bus.o_irq[1], xt(1), topei(70));
        end
    endtask

    task automatic test_id_zero();
        set_src(0, 0, 1'b1);
        apply_change(0);
        cycles(4);
        checks++;
        if ({bus.o_irq[0], xt(0)} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL id0_ignored: irq=%b xtopei[0]=%h want irq=0 xtopei=0",
                     bus.o_irq[0], xt(0));
        end
        set_src(0, 1, 1'b1);
        apply_change(0);
        cycles(4);
        checks++;
        if ({bus.o_irq[0], xt(0)} !== {1'b1, topei(1)}) begin
            errors++;
            $display("FAIL id1: irq=%b xtopei[0]=%h want irq=1 xtopei=%h",
                     bus.o_irq[0], xt(0), topei(1));
        end
        set_src(0, 0, 1'b0);
        set_src(0, 1, 1'b0);
        apply_change(0);
        cycles(4);
    endtask

    task automatic test_claim();
        bus.claim_vld  = 1'b1;
        bus.claim_file = 3'd1;
        @(negedge clk);
        bus.claim_vld = 1'b0;
        checks++;
        if ({bus.claim_ack, bus.claim_id} !== {1'b1, 8'd70}) begin
            errors++;
            $display("FAIL claim_resp: ack=%b id=%0d want ack=1 id=70",
                     bus.claim_ack, bus.claim_id);
        end
        checks++;
        if ({bus.eip_clr_vld, bus.eip_clr_file, bus.eip_clr_id} !== {1'b1, 3'd1, 8'd70}) begin
            errors++;
            $display("FAIL claim_clr: vld=%b file=%0d id=%0d want vld=1 file=1 id=70",
                     bus.eip_clr_vld, bus.eip_clr_file, bus.eip_clr_id);
        end
        checks++;
        if ({bus.o_irq[1], xt(1)} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL claim_invalidate: irq=%b xtopei[1]=%h want irq=0 xtopei=0",
                     bus.o_irq[1], xt(1));
        end
        cycles(3);
        checks++;
        if ({bus.claim_ack, bus.eip_clr_vld, xt(1)} !== {1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL claim_idle: ack=%b clr=%b xtopei[1]=%h want 0 0 0",
                     bus.claim_ack, bus.eip_clr_vld, xt(1));
        end
        cycles(1);
        checks++;
        if ({bus.o_irq[1], xt(1)} !== {1'b1, topei(200)}) begin
            errors++;
            $display("FAIL claim_mask: irq=%b xtopei[1]=%h want irq=1 xtopei=%h",
                     bus.o_irq[1], xt(1), topei(200));
        end
        cycles(4);
        checks++;
        if (xt(1) !== topei(70)) begin
            errors++;
            $display("FAIL mask_cleared: xtopei[1] got %h want %h", xt(1), topei(70));
        end
    endtask

    task automatic test_back_to_back();
        bus.claim_vld  = 1'b1;
        bus.claim_file = 3'd1;
        @(negedge clk);
        checks++;
        if ({bus.claim_ack, bus.claim_id, bus.eip_clr_vld} !== {1'b1, 8'd70, 1'b1}) begin
            errors++;
            $display("FAIL b2b_first: ack=%b id=%0d clr=%b want 1 70 1",
                     bus.claim_ack, bus.claim_id, bus.eip_clr_vld);
        end
        @(negedge clk);
        bus.claim_vld = 1'b0;
        checks++;
        if ({bus.claim_ack, bus.claim_id, bus.eip_clr_vld} !== {1'b1, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL b2b_second: ack=%b id=%0d clr=%b want 1 0 0",
                     bus.claim_ack, bus.claim_id, bus.eip_clr_vld);
        end
        // The second claim found nothing committed, so its mask is empty and 70 returns.
        cycles(3);
        checks++;
        if (xt(1) !== 32'h0) begin
            errors++;
            $display("FAIL b2b_hold: xtopei[1] got %h want 00000000", xt(1));
        end
        cycles(1);
        checks++;
        if (xt(1) !== topei(70)) begin
            errors++;
            $display("FAIL b2b_recommit: xtopei[1] got %h want %h", xt(1), topei(70));
        end
        bus.claim_vld  = 1'b1;
        bus.claim_file = 3'd7;
        @(negedge clk);
        bus.claim_vld = 1'b0;
        checks++;
        if ({bus.claim_ack, bus.claim_id, bus.eip_clr_vld, xt(1)} !==
            {1'b1, 8'd0, 1'b0, topei(70)}) begin
            errors++;
            $display("FAIL claim_oor: ack=%b id=%0d clr=%b xtopei[1]=%h want 1 0 0 %h",
                     bus.claim_ack, bus.claim_id, bus.eip_clr_vld, xt(1), topei(70));
        end
    endtask

    task automatic test_claim_cfg_collision();
        bus.claim_vld  = 1'b1;
        bus.claim_file = 3'd1;
        bus.cfg_chg[1] = 1'b1;
        @(negedge clk);
        bus.claim_vld  = 1'b0;
        bus.cfg_chg[1] = 1'b0;
        checks++;
        if ({bus.claim_ack, bus.claim_id, xt(1)} !== {1'b1, 8'd70, 32'h0}) begin
            errors++;
            $display("FAIL collide_resp: ack=%b id=%0d xtopei[1]=%h want 1 70 0",
                     bus.claim_ack, bus.claim_id, xt(1));
        end
        cycles(3);
        checks++;
        if (xt(1) !== 32'h0) begin
            errors++;
            $display("FAIL collide_hold: xtopei[1] got %h want 00000000", xt(1));
        end
        cycles(1);
        checks++;
        if (xt(1) !== topei(200)) begin
            errors++;
            $display("FAIL collide_mask: xtopei[1] got %h want %h", xt(1), topei(200));
        end
        cycles(4);
    endtask

    task automatic test_cfg_chg();
        set_src(2, 5, 1'b1);
        apply_change(2);
        cycles(4);
        checks++;
        if ({bus.o_irq[2], xt(2)} !== {1'b1, topei(5)}) begin
            errors++;
            $display("FAIL cfg_initial: irq=%b xtopei[2]=%h want irq=1 xtopei=%h",
                     bus.o_irq[2], xt(2), topei(5));
        end
        set_src(2, 3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i != 0) begin
                @(negedge clk);
                checks++;
                if ({bus.o_irq[2], xt(2)} !== {1'b1, topei(5)}) begin
                    errors++;
                    $display("FAIL cfg_glitch_gap%0d: irq=%b xtopei[2]=%h want irq=1 xtopei=%h",
                             i, bus.o_irq[2], xt(2), topei(5));
                end
            end
            apply_change(2);
            checks++;
            if ({bus.o_irq[2], xt(2)} !== {1'b1, topei(5)}) begin
                errors++;
                $display("FAIL cfg_glitch_pulse%0d: irq=%b xtopei[2]=%h want irq=1 xtopei=%h",
                         i, bus.o_irq[2], xt(2), topei(5));
            end
        end
        cycles(3);
        checks++;
        if (xt(2) !== topei(5)) begin
            errors++;
            $display("FAIL cfg_settle_early: xtopei[2] got %h want %h", xt(2), topei(5));
        end
        cycles(1);
        checks++;
        if ({bus.o_irq[2], xt(2)} !== {1'b1, topei(3)}) begin
            errors++;
            $display("FAIL cfg_settle: irq=%b xtopei[2]=%h want irq=1 xtopei=%h",
                     bus.o_irq[2], xt(2), topei(3));
        end
    endtask

    task automatic test_eidelivery();
        bus.eidelivery[2] = 1'b0;
        #1;
        checks++;
        if (bus.o_irq[2] !== 1'b1) begin
            errors++;
            $display("FAIL deliv_registered: o_irq[2] got %b want 1", bus.o_irq[2]);
        end
        @(negedge clk);
        checks++;
        if ({bus.o_irq[2], xt(2)} !== {1'b0, topei(3)}) begin
            errors++;
            $display("FAIL deliv_off: irq=%b xtopei[2]=%h want irq=0 xtopei=%h",
                     bus.o_irq[2], xt(2), topei(3));
        end
        bus.eidelivery[2] = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.o_irq[2] !== 1'b1) begin
            errors++;
            $display("FAIL deliv_on: o_irq[2] got %b want 1", bus.o_irq[2]);
        end
    endtask

    task automatic test_reset_mid_claim();
        bus.claim_vld  = 1'b1;
        bus.claim_file = 3'd1;
        rstn           = 1'b0;
        #1;
        checks++;
        if ({bus.claim_ack, bus.eip_clr_vld, bus.o_irq, bus.xtopei} !== '0) begin
            errors++;
            $display("FAIL rst_claim_now: ack=%b clr=%b irq=%b xtopei=%h want all 0",
                     bus.claim_ack, bus.eip_clr_vld, bus.o_irq, bus.xtopei);
        end
        @(negedge clk);
        checks++;
        if ({bus.claim_ack, bus.eip_clr_vld} !== 2'b00) begin
            errors++;
            $display("FAIL rst_claim_edge: ack=%b clr=%b want 0 0",
                     bus.claim_ack, bus.eip_clr_vld);
        end
        rstn          = 1'b1;
        bus.claim_vld = 1'b0;
        cycles(4);
        checks++;
        if ({bus.o_irq, xt(1), xt(2)} !== {7'b0000110, topei(70), topei(3)}) begin
            errors++;
            $display("FAIL rst_resume: irq=%b x1=%h x2=%h want 0000110 %h %h",
                     bus.o_irq, xt(1), xt(2), topei(70), topei(3));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_scan();
        test_threshold();
        test_id_zero();
        test_claim();
        test_back_to_back();
        test_claim_cfg_collision();
        test_cfg_chg();
        test_eidelivery();
        test_reset_mid_claim();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
